// File: rtl/hub75_column_driver.sv
// HUB75 column driver: captures one upper/lower column pair, shifts it out as three
// binary-weighted bit-planes (LSB first) and paces the upstream frame manager via hub75_ready.
module hub75_column_driver #(
  parameter int NUM_ROWS      = 64,
  parameter int SCAN_RATE     = 32,
  parameter int RGB_RES       = 9,
  parameter int OE_BASE       = 32,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns,
  input  logic [$clog2(SCAN_RATE)-1:0]           col_num1,
  input  logic [$clog2(SCAN_RATE):0]             col_num2,
  input  logic                                   data_valid,
  output logic                                   hub75_ready,
  output logic [$clog2(SCAN_RATE)-1:0]           hub75_addr,
  output logic                                   hub75_r0,
  output logic                                   hub75_g0,
  output logic                                   hub75_b0,
  output logic                                   hub75_r1,
  output logic                                   hub75_g1,
  output logic                                   hub75_b1,
  output logic                                   hub75_clk,
  output logic                                   hub75_latch,
  output logic                                   hub75_oe
);

  localparam int PLANES = RGB_RES / 3;
  localparam int ADDR_W = $clog2(SCAN_RATE);
  localparam int PIX_W  = $clog2(NUM_ROWS);
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TO_W   = $clog2(READY_TIMEOUT + 1);
  localparam int DT_W   = $clog2((OE_BASE << (PLANES - 1)) + 1);

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(READY_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_SAT    = TO_W'(READY_TIMEOUT);
  localparam logic [PIX_W-1:0] PIX_FIRST = PIX_W'(NUM_ROWS - 1);
  localparam logic [PL_W-1:0]  PL_LAST   = PL_W'(PLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_WAIT,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  // Select the R/G/B bits belonging to one bit-plane of a packed pixel.
  function automatic logic [2:0] pick_rgb(input logic [RGB_RES-1:0] px,
                                          input logic [PL_W-1:0]    pl);
    logic [RGB_RES-1:0] sh;
    sh = px >> pl;
    return {sh[2*PLANES], sh[PLANES], sh[0]};
  endfunction

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_buf;
  logic [ADDR_W-1:0]                     r_col;
  logic [PL_W-1:0]                       r_plane;
  logic [PL_W-1:0]                       w_plane_nxt;
  logic [PIX_W-1:0]                      r_pixel;
  logic [PIX_W-1:0]                      w_pixel_nxt;
  logic                                  r_phase;
  logic                                  w_phase_nxt;
  logic [TO_W-1:0]                       r_to_cnt;
  logic [TO_W-1:0]                       w_to_nxt;
  logic [DT_W-1:0]                       r_disp_cnt;
  logic [DT_W-1:0]                       w_disp_nxt;
  logic                                  w_capture;
  logic                                  w_addr_load;

  logic                                  r_ready;
  logic [ADDR_W-1:0]                     r_addr;
  logic [5:0]                            r_rgb;
  logic                                  r_clk;
  logic                                  r_latch;
  logic                                  r_oe;

  logic [RGB_RES-1:0]                    w_px0;
  logic [RGB_RES-1:0]                    w_px1;
  logic                                  w_unused;

  assign w_unused = ^col_num2;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_col      <= '0;
      r_plane    <= '0;
      r_pixel    <= '0;
      r_phase    <= 1'b0;
      r_to_cnt   <= '0;
      r_disp_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_plane    <= w_plane_nxt;
      r_pixel    <= w_pixel_nxt;
      r_phase    <= w_phase_nxt;
      r_to_cnt   <= w_to_nxt;
      r_disp_cnt <= w_disp_nxt;
      if (w_capture) begin
        r_buf <= columns;
        r_col <= col_num1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_plane_nxt = r_plane;
    w_pixel_nxt = r_pixel;
    w_phase_nxt = r_phase;
    w_to_nxt    = r_to_cnt;
    w_disp_nxt  = r_disp_cnt;
    w_capture   = 1'b0;
    w_addr_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_READY;
      end
      S_READY: begin
        w_to_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // data_valid takes priority over a simultaneous timeout
        if (data_valid) begin
          w_capture   = 1'b1;
          w_plane_nxt = '0;
          w_pixel_nxt = PIX_FIRST;
          w_phase_nxt = 1'b0;
          w_state_nxt = S_SHIFT;
        end else if (r_to_cnt >= TO_LAST) begin
          w_state_nxt = S_READY;
        end else if (r_to_cnt != TO_SAT) begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_SHIFT: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (r_pixel == '0) begin
            w_addr_load = 1'b1;
            w_state_nxt = S_LATCH;
          end else begin
            w_pixel_nxt = r_pixel - PIX_W'(1);
          end
        end
      end
      S_LATCH: begin
        w_disp_nxt  = DT_W'((OE_BASE << r_plane) - 1);
        w_state_nxt = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (r_disp_cnt == '0) begin
          if (r_plane < PL_LAST) begin
            w_plane_nxt = r_plane + PL_W'(1);
            w_pixel_nxt = PIX_FIRST;
            w_phase_nxt = 1'b0;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_READY;
          end
        end else begin
          w_disp_nxt = r_disp_cnt - DT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pixel source for the coming cycle: the live bus on the capture edge, else the buffer.
  assign w_px0 = w_capture ? columns[0][w_pixel_nxt] : r_buf[0][w_pixel_nxt];
  assign w_px1 = w_capture ? columns[1][w_pixel_nxt] : r_buf[1][w_pixel_nxt];

  // Panel outputs are registered from next-state values so they are glitch-free
  // and line up cycle-for-cycle with the state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_rgb   <= '0;
      r_clk   <= 1'b0;
      r_latch <= 1'b0;
      r_oe    <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt == S_READY);
      r_clk   <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
      r_latch <= (w_state_nxt == S_LATCH);
      r_oe    <= (w_state_nxt != S_DISPLAY);
      if (w_state_nxt == S_SHIFT) begin
        r_rgb <= {pick_rgb(w_px1, w_plane_nxt), pick_rgb(w_px0, w_plane_nxt)};
      end else begin
        r_rgb <= '0;
      end
      if (w_addr_load) begin
        r_addr <= r_col;
      end
    end
  end

  assign hub75_ready = r_ready;
  assign hub75_addr  = r_addr;
  assign hub75_r1    = r_rgb[5];
  assign hub75_g1    = r_rgb[4];
  assign hub75_b1    = r_rgb[3];
  assign hub75_r0    = r_rgb[2];
  assign hub75_g0    = r_rgb[1];
  assign hub75_b0    = r_rgb[0];
  assign hub75_clk   = r_clk;
  assign hub75_latch = r_latch;
  assign hub75_oe    = r_oe;

endmodule
